// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential 4x4 multiplier controller.
// The FSM state encoding and operand/product widths live here.
package mul_seq_pkg;

  localparam int MUL_WIDTH  = 4;
  localparam int MUL_ITERS  = 4;
  localparam int PROD_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } mul_state_t;

endpackage

// File: rtl/mul_seq_add_op.sv
// 4-bit ripple-carry adder shared with the ALU path.
// The carry-out is returned as result[4] so callers never lose it.
module add_op (
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  output logic [4:0] result
);

  logic [4:0] carry;

  // Ripple the carry through four full-adder stages.
  always_comb begin
    carry  = 5'b0_0000;
    result = 5'b0_0000;
    for (int i = 0; i < 4; i++) begin
      result[i]  = num1[i] ^ num2[i] ^ carry[i];
      carry[i+1] = (num1[i] & num2[i]) | (carry[i] & (num1[i] ^ num2[i]));
    end
    result[4] = carry[4];
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential 4x4 unsigned multiplier: one conditional add-and-shift per clock
// through add_op, start/done pulse handshake, registered 8-bit product.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int ITERS = MUL_ITERS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      num1,
  input  logic [WIDTH-1:0]      num2,
  output logic                  busy,
  output logic                  done,
  output logic [PROD_WIDTH-1:0] product
);

  localparam logic [1:0] LAST_ITER = 2'(ITERS - 1);

  mul_state_t state, state_next;
  logic [WIDTH-1:0]      m, m_next;
  logic [WIDTH-1:0]      acc, acc_next;
  logic [WIDTH-1:0]      q, q_next;
  logic [1:0]            cnt, cnt_next;
  logic                  busy_next;
  logic                  done_next;
  logic [PROD_WIDTH-1:0] product_next;
  logic [WIDTH-1:0]      addend;
  logic [WIDTH:0]        s;

  assign addend = q[0] ? m : {WIDTH{1'b0}};

  add_op u_add_op (
    .num1   (acc),
    .num2   (addend),
    .result (s)
  );

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_next   = state;
    m_next       = m;
    acc_next     = acc;
    q_next       = q;
    cnt_next     = cnt;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    product_next = product;
    case (state)
      IDLE: begin
        if (start) begin
          m_next     = num1;
          q_next     = num2;
          acc_next   = {WIDTH{1'b0}};
          cnt_next   = 2'd0;
          state_next = CALC;
          busy_next  = 1'b1;
        end else begin
          busy_next  = 1'b0;
        end
      end
      CALC: begin
        // Carry s[WIDTH] shifts into acc, s[0] into the top of q.
        acc_next = s[WIDTH:1];
        q_next   = {s[0], q[WIDTH-1:1]};
        cnt_next = cnt + 2'd1;
        if (cnt == LAST_ITER) begin
          state_next   = IDLE;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          product_next = {s[WIDTH:1], s[0], q[WIDTH-1:1]};
        end else begin
          busy_next    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      m       <= {WIDTH{1'b0}};
      acc     <= {WIDTH{1'b0}};
      q       <= {WIDTH{1'b0}};
      cnt     <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= {PROD_WIDTH{1'b0}};
    end else begin
      state   <= state_next;
      m       <= m_next;
      acc     <= acc_next;
      q       <= q_next;
      cnt     <= cnt_next;
      busy    <= busy_next;
      done    <= done_next;
      product <= product_next;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq; inputs driven and outputs
// sampled on the falling clock edge, away from the active rising edge.
module tb_mul_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] num1;
  logic [3:0] num2;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int vectors = 0;
  int errors  = 0;

  mul_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .num1    (num1),
    .num2    (num2),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle, then wait (bounded) for done; lat counts falling edges.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int lat);
    num1  = a;
    num2  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; num1 = 4'd0; num2 = 4'd0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b product=%h, want 0 0 00", busy, done, product);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_max;
    num1 = 4'd15; num2 = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL max_busy[%0d]: busy=%b done=%b, want 1 0", i, busy, done);
      end
      @(negedge clk);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || product !== 8'hE1) begin
      errors++;
      $display("FAIL max_done: done=%b busy=%b product=%h, want 1 0 e1", done, busy, product);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || product !== 8'hE1) begin
      errors++;
      $display("FAIL max_pulse: done=%b product=%h, want 0 e1", done, product);
    end
  endtask

  task automatic test_zero;
    int lat;
    run_op(4'd0, 4'd9, lat);
    vectors++;
    if (lat !== 5 || product !== 8'h00) begin
      errors++;
      $display("FAIL zero_0x9: latency=%0d product=%h, want 5 00", lat, product);
    end
    @(negedge clk);
    run_op(4'd9, 4'd0, lat);
    vectors++;
    if (lat !== 5 || product !== 8'h00) begin
      errors++;
      $display("FAIL zero_9x0: latency=%0d product=%h, want 5 00", lat, product);
    end
    @(negedge clk);
  endtask

  task automatic test_hold;
    int lat;
    run_op(4'd13, 4'd11, lat);
    vectors++;
    if (lat !== 5 || product !== 8'h8F) begin
      errors++;
      $display("FAIL mul_13x11: latency=%0d product=%h, want 5 8f", lat, product);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (product !== 8'h8F || done !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: product=%h done=%b, want 8f 0", i, product, done);
      end
    end
  endtask

  task automatic test_ignore_busy;
    int n_done;
    n_done = 0;
    num1 = 4'd7; num2 = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    num1 = 4'd3; num2 = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) begin
        n_done++;
        vectors++;
        if (product !== 8'h2A) begin
          errors++;
          $display("FAIL ignore_product: product=%h, want 2a", product);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL ignore_count: done pulses=%0d, want 1", n_done);
    end
  endtask

  task automatic test_back_to_back;
    num1 = 4'd5; num2 = 4'd3; start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      vectors++;
      if (done !== ((k % 5) == 0)) begin
        errors++;
        $display("FAIL b2b_done[%0d]: done=%b, want %b", k, done, (k % 5) == 0);
      end
      if ((k % 5) == 0) begin
        vectors++;
        if (product !== 8'h0F) begin
          errors++;
          $display("FAIL b2b_product[%0d]: product=%h, want 0f", k, product);
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int lat;
    num1 = 4'd15; num2 = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      errors++;
      $display("FAIL abort_reset: busy=%b done=%b product=%h, want 0 0 00", busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet[%0d]: done=%b busy=%b, want 0 0", i, done, busy);
      end
    end
    run_op(4'd2, 4'd3, lat);
    vectors++;
    if (lat !== 5 || product !== 8'h06) begin
      errors++;
      $display("FAIL abort_recover: latency=%0d product=%h, want 5 06", lat, product);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_max();
    test_zero();
    test_hold();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
